// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling default and stop-period presets.
// Used by both uart_tx and uart_rx.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int OVERSAMPLE_DEF = 16;

  // Stop period length in ticks for 1, 1.5 and 2 stop bits at 16x oversampling.
  localparam int SB_TICK_1   = 16;
  localparam int SB_TICK_1P5 = 24;
  localparam int SB_TICK_2   = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB-first, stop period,
// paced by the shared oversampling tick. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int SW = max2(1, $clog2(max2(OVERSAMPLE, SB_TICK)));
  localparam int NW = max2(1, $clog2(NB_DATA));

  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NB_LAST = NW'(NB_DATA - 1);

  logic [1:0]         state;
  logic [SW-1:0]      s_cnt;
  logic [NW-1:0]      n_cnt;
  logic [NB_DATA-1:0] b_reg;
  logic [NB_DATA-1:0] b_next;

  assign b_next = b_reg >> 1;

  // o_tx is registered together with the state so the line level always
  // matches the bit the FSM is currently timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      b_reg     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_tx <= 1'b1;
          if (i_tx_start) begin
            b_reg     <= i_tx_data;
            s_cnt     <= '0;
            state     <= ST_START;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (i_tick) begin
            if (s_cnt == OS_LAST) begin
              s_cnt <= '0;
              n_cnt <= '0;
              state <= ST_DATA;
              o_tx  <= b_reg[0];
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        ST_DATA: begin
          if (i_tick) begin
            if (s_cnt == OS_LAST) begin
              s_cnt <= '0;
              b_reg <= b_next;
              if (n_cnt == NB_LAST) begin
                state <= ST_STOP;
                o_tx  <= 1'b1;
              end else begin
                n_cnt <= n_cnt + NW'(1);
                o_tx  <= b_next[0];
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        default: begin
          o_tx <= 1'b1;
          if (i_tick) begin
            if (s_cnt == SB_LAST) begin
              s_cnt     <= '0;
              state     <= ST_IDLE;
              o_tx_busy <= 1'b0;
              o_tx_done <= 1'b1;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-tick line levels are compared against a
// frame model built from bit timing arithmetic, plus done/busy timing and decode.
module tb_uart_tx;

  localparam int OS = 16;
  localparam int NB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sel = 1'b0;

  logic tx0, busy0, done0, tx32, busy32, done32;
  logic start0, start32;
  logic tx_m, busy_m, done_m;

  assign start0  = tx_start & ~sel;
  assign start32 = tx_start & sel;
  assign tx_m    = sel ? tx32 : tx0;
  assign busy_m  = sel ? busy32 : busy0;
  assign done_m  = sel ? done32 : done0;

  uart_tx #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_tx_start(start0),
    .i_tx_data(tx_data), .o_tx(tx0), .o_tx_busy(busy0), .o_tx_done(done0)
  );

  uart_tx #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_tx_start(start32),
    .i_tx_data(tx_data), .o_tx(tx32), .o_tx_busy(busy32), .o_tx_done(done32)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int div = 1;
  int tcnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and decide whether this cycle carries a tick.
  task automatic next_cycle();
    @(negedge clk);
    tcnt++;
    tick = (tcnt % div) == 0;
  endtask

  // Reference line level for tick j of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j < OS) return 1'b0;
    if (j < (1 + NB) * OS) return d[(j - OS) / OS];
    return 1'b1;
  endfunction

  task automatic req(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
  endtask

  // Runs a frame whose request is pending in the current cycle. Returns in the
  // done cycle (or right after reset release when abort_at >= 0).
  task automatic run_frame(input logic [7:0] d, input int sb, input bit inject,
                           input int abort_at);
    int frame = (1 + NB) * OS + sb;
    int j = 0;
    int cyc = 0;
    logic [7:0] dec = 8'h00;
    next_cycle();
    cyc++;
    tx_start = 1'b0;
    chk("accept_busy", int'(busy_m), 1);
    chk("accept_tx", int'(tx_m), 0);
    while (j < frame) begin
      if (cyc > 4000) begin
        chk("timeout", 1, 0);
        return;
      end
      if (abort_at >= 0 && j == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_tx", int'(tx_m), 1);
        chk("abort_busy", int'(busy_m), 0);
        for (int k = 0; k < 3; k++) begin
          next_cycle();
          chk("abort_done", int'(done_m), 0);
        end
        rst_n = 1'b1;
        return;
      end
      tx_start = (inject && j == 50);
      if (inject && j == 50) tx_data = 8'hFF;
      if (tick) begin
        chk("line", int'(tx_m), int'(exp_bit(d, j)));
        chk("no_early_done", int'(done_m), 0);
        if (j >= OS && j < (1 + NB) * OS && (j % OS) == OS / 2)
          dec[(j - OS) / OS] = tx_m;
        j++;
      end
      next_cycle();
      cyc++;
    end
    tx_start = 1'b0;
    chk("done", int'(done_m), 1);
    chk("done_busy", int'(busy_m), 0);
    chk("done_tx", int'(tx_m), 1);
    chk("decode", int'(dec), int'(d));
    if (div == 1) chk("done_latency", cyc, frame + 1);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    // Reset state
    next_cycle();
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    rst_n = 1'b1;

    // Idle with sparse ticks, no request
    div = 4;
    for (int i = 0; i < 1000; i++) begin
      next_cycle();
      chk("idle_tx", int'(tx0), 1);
      chk("idle_busy", int'(busy0), 0);
      chk("idle_done", int'(done0), 0);
    end

    // 8'hA5, tick every clock
    div = 1;
    next_cycle();
    req(8'hA5);
    run_frame(8'hA5, 16, 1'b0, -1);

    // 8'h3C with a dropped request for 8'hFF mid-frame
    next_cycle();
    req(8'h3C);
    run_frame(8'h3C, 16, 1'b1, -1);
    next_cycle();
    chk("no_queued_frame", int'(busy0), 0);

    // Back-to-back 8'h01 then 8'h80, second request in the done cycle
    next_cycle();
    req(8'h01);
    run_frame(8'h01, 16, 1'b0, -1);
    req(8'h80);
    run_frame(8'h80, 16, 1'b0, -1);

    // Two stop bits: 176-tick frame
    sel = 1'b1;
    next_cycle();
    req(8'h00);
    run_frame(8'h00, 32, 1'b0, -1);
    sel = 1'b0;

    // Reset at tick 70, then 8'h5A
    next_cycle();
    req(8'hC3);
    run_frame(8'hC3, 16, 1'b0, 70);
    next_cycle();
    chk("post_abort_idle", int'(busy0), 0);
    req(8'h5A);
    run_frame(8'h5A, 16, 1'b0, -1);

    // Randomized frames with varying tick rate and occasional back-to-back pairs
    for (int i = 0; i < 12; i++) begin
      div = $urandom_range(1, 3);
      d = 8'($urandom);
      next_cycle();
      req(d);
      run_frame(d, 16, 1'b0, -1);
      if ($urandom_range(0, 1) == 1) begin
        d2 = 8'($urandom);
        req(d2);
        run_frame(d2, 16, 1'b0, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
